// File: rtl/button_gesture.sv
// Gesture controller: turns a debounced button level into short/long/double press pulses.
// Define BUTTON_GESTURE_REPEAT_EN to get auto-repeat pulses while a long press is held.
module button_gesture #(
  parameter int LONG_CYCLES   = 12_000_000,
  parameter int DOUBLE_CYCLES = 3_600_000,
  parameter int REPEAT_CYCLES = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  localparam int MAX_LD     = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HELD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // Every state exits at or before its terminal count, so count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
      repeat_press <= 1'b0;
`endif
      busy         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
      repeat_press <= 1'b0;
`endif
      case (state)
        IDLE: begin
          count <= '0;
          if (in) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (!in) begin
            state <= WAIT2;
            count <= '0;
          end else if (count == LONG_LAST) begin
            state      <= LONG_HELD;
            count      <= '0;
            long_press <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        // A press landing on the timeout cycle still becomes the second press.
        WAIT2: begin
          if (in) begin
            state <= PRESS2;
            count <= '0;
          end else if (count == DOUBLE_LAST) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            short_press <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        PRESS2: begin
          count <= '0;
          if (!in) begin
            state        <= IDLE;
            busy         <= 1'b0;
            double_press <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (!in) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
          end else if (count == REPEAT_LAST) begin
            count        <= '0;
            repeat_press <= 1'b1;
          end else begin
            count <= count + 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef BUTTON_GESTURE_REPEAT_EN
  assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with a pulse scoreboard (LONG=8, DOUBLE=5, REPEAT=4).
module tb_button_gesture;

  localparam logic [3:0] K_SHORT  = 4'b0001;
  localparam logic [3:0] K_LONG   = 4'b0010;
  localparam logic [3:0] K_DOUBLE = 4'b0100;
  localparam logic [3:0] K_REPEAT = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    int         cycle;
  } exp_t;

  logic clk;
  logic rst;
  logic in;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_press;
  logic busy;

  int   checks;
  int   failures;
  int   cyc;
  exp_t exp_q[$];

  button_gesture #(
    .LONG_CYCLES  (8),
    .DOUBLE_CYCLES(5),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .repeat_press(repeat_press),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", name, cyc, observed, expected);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] kind, input int cycle);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    exp_q.push_back(e);
  endtask

  // Any pulse seen must match the head of the scoreboard in kind and cycle.
  task automatic monitor_pulses();
    logic [3:0] kind;
    exp_t       e;
    kind = {repeat_press, double_press, long_press, short_press};
    if (kind != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", int'(kind), 0);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_kind", int'(kind), int'(e.kind));
        check_output("pulse_cycle", cyc, e.cycle);
      end
    end
  endtask

  // Drive 'value' for n cycles; after each edge, outputs belong to the next cycle.
  task automatic apply_stimulus(input logic value, input int n);
    for (int i = 0; i < n; i++) begin
      in = value;
      @(posedge clk);
      #1;
      cyc++;
      monitor_pulses();
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_short"}, int'(short_press), 0);
    check_output({tag, "_long"}, int'(long_press), 0);
    check_output({tag, "_double"}, int'(double_press), 0);
    check_output({tag, "_repeat"}, int'(repeat_press), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(1'b0, 2);
    rst = 1'b0;
    apply_stimulus(1'b0, 1);
    check_idle("reset");
    cyc = 0;
  endtask

  task automatic check_drained(input string tag);
    check_output({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b0;
    in       = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] short press");
    do_reset();
    expect_pulse(K_SHORT, 9);
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 5);
    check_output("short_busy_c8", int'(busy), 1);
    apply_stimulus(1'b0, 1);
    check_output("short_busy_c9", int'(busy), 0);
    apply_stimulus(1'b0, 4);
    check_drained("short");

    $display("[TB] long press");
    do_reset();
    expect_pulse(K_LONG, 9);
    apply_stimulus(1'b1, 12);
    check_output("long_busy_c12", int'(busy), 1);
    apply_stimulus(1'b0, 1);
    check_output("long_busy_c13", int'(busy), 0);
    apply_stimulus(1'b0, 8);
    check_drained("long");

    $display("[TB] double press");
    do_reset();
    expect_pulse(K_DOUBLE, 7);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 2);
    check_output("double_busy_c6", int'(busy), 1);
    apply_stimulus(1'b0, 1);
    check_output("double_busy_c7", int'(busy), 0);
    apply_stimulus(1'b0, 8);
    check_drained("double");

    $display("[TB] second press on the wait timeout cycle");
    do_reset();
    expect_pulse(K_DOUBLE, 11);
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 5);
    apply_stimulus(1'b1, 2);
    check_output("edge_busy_c10", int'(busy), 1);
    apply_stimulus(1'b0, 8);
    check_output("edge_busy_end", int'(busy), 0);
    check_drained("edge");

    $display("[TB] extended hold");
    do_reset();
    expect_pulse(K_LONG, 9);
`ifdef BUTTON_GESTURE_REPEAT_EN
    expect_pulse(K_REPEAT, 13);
    expect_pulse(K_REPEAT, 17);
`endif
    apply_stimulus(1'b1, 20);
    apply_stimulus(1'b0, 6);
    check_output("hold_busy_end", int'(busy), 0);
    check_drained("hold");

    $display("[TB] reset mid-gesture");
    do_reset();
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 3);
    rst = 1'b1;
    apply_stimulus(1'b0, 1);
    rst = 1'b0;
    check_idle("midrst_c7");
    apply_stimulus(1'b0, 10);
    check_idle("midrst_end");
    check_drained("midrst");

    $display("[TB] press held through reset release");
    do_reset();
    rst = 1'b1;
    apply_stimulus(1'b1, 1);
    rst = 1'b0;
    cyc = 0;
    expect_pulse(K_SHORT, 9);
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 9);
    check_drained("rsthold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
